// File: rtl/rbsp_epb_buffer.sv
// Strips H.264 emulation-prevention bytes from the NALU byte stream and packs the
// resulting RBSP bits MSB-first into a bit buffer that exposes a left-aligned window.
module rbsp_epb_buffer #(
  parameter int unsigned BUF_W = 64,
  parameter int unsigned WIN_W = 32,
  parameter int unsigned LEN_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     flush,
  input  logic                     stream_mem_valid,
  input  logic [7:0]               stream_mem_data,
  output logic                     stream_mem_rd,
  input  logic                     forward_ena,
  input  logic [LEN_W-1:0]         forward_len,
  output logic                     rbsp_buffer_valid,
  output logic [WIN_W-1:0]         rbsp_data,
  output logic [$clog2(BUF_W):0]   bit_count,
  output logic [15:0]              epb_count
);

  localparam int unsigned CNT_W = $clog2(BUF_W) + 1;
  localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(BUF_W - 8);
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN_W);
  localparam logic [LEN_W-1:0] WIN_LEN  = LEN_W'(WIN_W);

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_d;
  logic [BUF_W-1:0] kept;
  logic [BUF_W-1:0] byte_ext;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_after;
  logic [CNT_W-1:0] cons_len;
  logic [LEN_W-1:0] len_sat;
  logic [1:0]       zc_q;
  logic [1:0]       zc_d;
  logic [15:0]      epb_d;
  logic             valid_d;
  logic             accept;
  logic             drop;
  logic             consume;

  // Byte request: eligibility uses the pre-consume fill level so a byte always fits.
  assign stream_mem_rd = ena && !flush && !rst && (bit_count <= RD_LIMIT);
  assign accept        = stream_mem_rd && stream_mem_valid;
  assign drop          = accept && (zc_q == 2'd2) && (stream_mem_data == 8'h03);
  assign rbsp_data     = buf_q[BUF_W-1 -: WIN_W];

  // Consume-then-append datapath; the new byte lands right behind the surviving bits.
  always_comb begin
    len_sat   = (forward_len > WIN_LEN) ? WIN_LEN : forward_len;
    consume   = ena && !flush && forward_ena && rbsp_buffer_valid;
    cons_len  = consume ? CNT_W'(len_sat) : '0;
    kept      = buf_q << cons_len;
    cnt_after = bit_count - cons_len;
    byte_ext  = {stream_mem_data, {(BUF_W-8){1'b0}}};
    buf_d     = kept;
    cnt_d     = cnt_after;
    zc_d      = zc_q;
    epb_d     = epb_count;
    if (flush) begin
      buf_d = '0;
      cnt_d = '0;
      zc_d  = 2'd0;
      epb_d = 16'd0;
    end else if (accept) begin
      if (drop) begin
        zc_d  = 2'd0;
        epb_d = (epb_count == 16'hFFFF) ? epb_count : epb_count + 16'd1;
      end else begin
        buf_d = kept | (byte_ext >> cnt_after);
        cnt_d = cnt_after + CNT_W'(8);
        if (stream_mem_data == 8'h00) begin
          zc_d = (zc_q == 2'd2) ? 2'd2 : zc_q + 2'd1;
        end else begin
          zc_d = 2'd0;
        end
      end
    end
    valid_d = (cnt_d >= WIN_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q             <= '0;
      bit_count         <= '0;
      zc_q              <= 2'd0;
      epb_count         <= 16'd0;
      rbsp_buffer_valid <= 1'b0;
    end else begin
      buf_q             <= buf_d;
      bit_count         <= cnt_d;
      zc_q              <= zc_d;
      epb_count         <= epb_d;
      rbsp_buffer_valid <= valid_d;
    end
  end

endmodule
